// File: rtl/i2c_xfer_seq.sv
// I2C register-transaction sequencer: turns one register read/write request into
// START/WRITE/READ/STOP byte commands. Optional NACK retry: I2C_XFER_SEQ_RETRY_EN.
module i2c_xfer_seq #(
    parameter int unsigned RETRY_NUM = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdat_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_rdat_o,
    output logic       rsp_nack_o,
    output logic       rsp_al_o,
    output logic       busy_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       read_o,
    output logic       write_o,
    output logic       ack_o,
    output logic [7:0] dat_o,
    input  logic       cmd_ack_i,
    input  logic       ack_i,
    input  logic [7:0] dat_i,
    input  logic       al_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEVW, S_REG, S_WDAT, S_RSTA, S_RDAT, S_STOP, S_RESP
    } state_t;

    state_t     state;
    logic       issued;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdat_q;
    logic       nack_q;

    logic       c_sta, c_sto, c_rd, c_wr, c_ack;
    logic [7:0] c_dat;

`ifdef I2C_XFER_SEQ_RETRY_EN
    localparam int unsigned CW = (RETRY_NUM < 3) ? 2 : $clog2(RETRY_NUM + 1);
    logic [CW-1:0] retry_cnt;
    logic          dev_nack_q;
`endif

    assign req_ready_o = en_i & (state == S_IDLE) & ~rsp_valid_o;

    // Command pattern for the current state; loaded into the output registers
    // one cycle after state entry.
    always_comb begin
        c_sta = 1'b0;
        c_sto = 1'b0;
        c_rd  = 1'b0;
        c_wr  = 1'b0;
        c_ack = 1'b0;
        c_dat = '0;
        case (state)
            S_DEVW: begin c_sta = 1'b1; c_wr = 1'b1; c_dat = {dev_q, 1'b0}; end
            S_REG:  begin c_wr = 1'b1; c_dat = reg_q; end
            S_WDAT: begin c_wr = 1'b1; c_sto = 1'b1; c_dat = wdat_q; end
            S_RSTA: begin c_sta = 1'b1; c_wr = 1'b1; c_dat = {dev_q, 1'b1}; end
            S_RDAT: begin c_rd = 1'b1; c_sto = 1'b1; c_ack = 1'b1; end
            S_STOP: begin c_sto = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            issued      <= 1'b0;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdat_q      <= '0;
            nack_q      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdat_o  <= '0;
            rsp_nack_o  <= 1'b0;
            rsp_al_o    <= 1'b0;
            busy_o      <= 1'b0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            read_o      <= 1'b0;
            write_o     <= 1'b0;
            ack_o       <= 1'b0;
            dat_o       <= '0;
`ifdef I2C_XFER_SEQ_RETRY_EN
            retry_cnt   <= '0;
            dev_nack_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_ready_o && req_valid_i) begin
                        rnw_q      <= req_rnw_i;
                        dev_q      <= req_dev_i;
                        reg_q      <= req_reg_i;
                        wdat_q     <= req_wdat_i;
                        nack_q     <= 1'b0;
                        issued     <= 1'b0;
                        rsp_rdat_o <= '0;
                        rsp_nack_o <= 1'b0;
                        rsp_al_o   <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= S_DEVW;
`ifdef I2C_XFER_SEQ_RETRY_EN
                        retry_cnt  <= '0;
                        dev_nack_q <= 1'b0;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    // Arbitration loss wins over a same-cycle cmd_ack_i: the bus is
                    // no longer ours, so no STOP is attempted.
                    if (al_i) begin
                        {start_o, stop_o, read_o, write_o, ack_o} <= '0;
                        dat_o       <= '0;
                        issued      <= 1'b0;
                        rsp_al_o    <= 1'b1;
                        rsp_nack_o  <= 1'b0;
                        rsp_rdat_o  <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end else if (!issued) begin
                        start_o <= c_sta;
                        stop_o  <= c_sto;
                        read_o  <= c_rd;
                        write_o <= c_wr;
                        ack_o   <= c_ack;
                        dat_o   <= c_dat;
                        issued  <= 1'b1;
                    end else if (cmd_ack_i) begin
                        {start_o, stop_o, read_o, write_o, ack_o} <= '0;
                        dat_o  <= '0;
                        issued <= 1'b0;
                        case (state)
                            S_DEVW: begin
                                if (ack_i) begin
                                    nack_q <= 1'b1;
`ifdef I2C_XFER_SEQ_RETRY_EN
                                    dev_nack_q <= 1'b1;
`endif
                                    state  <= S_STOP;
                                end else begin
                                    state <= S_REG;
                                end
                            end
                            S_REG: begin
                                if (ack_i) begin
                                    nack_q <= 1'b1;
                                    state  <= S_STOP;
                                end else begin
                                    state <= rnw_q ? S_RSTA : S_WDAT;
                                end
                            end
                            S_WDAT: begin
                                rsp_nack_o  <= ack_i;
                                rsp_valid_o <= 1'b1;
                                state       <= S_RESP;
                            end
                            S_RSTA: begin
                                if (ack_i) begin
                                    nack_q <= 1'b1;
                                    state  <= S_STOP;
                                end else begin
                                    state <= S_RDAT;
                                end
                            end
                            S_RDAT: begin
                                rsp_rdat_o  <= dat_i;
                                rsp_valid_o <= 1'b1;
                                state       <= S_RESP;
                            end
                            S_STOP: begin
`ifdef I2C_XFER_SEQ_RETRY_EN
                                if (dev_nack_q && (retry_cnt < CW'(RETRY_NUM))) begin
                                    retry_cnt  <= retry_cnt + CW'(1);
                                    dev_nack_q <= 1'b0;
                                    nack_q     <= 1'b0;
                                    state      <= S_DEVW;
                                end else
`endif
                                begin
                                    rsp_nack_o  <= nack_q;
                                    rsp_valid_o <= 1'b1;
                                    state       <= S_RESP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq: a vector table of register transactions served by
// a cycle-level byte-controller responder, plus reset/enable sequences.
module tb_i2c_xfer_seq;

    logic       clk_i = 1'b0;
    logic       rst_n_i, en_i, req_valid_i, req_ready_o, req_rnw_i;
    logic [6:0] req_dev_i;
    logic [7:0] req_reg_i, req_wdat_i;
    logic       rsp_valid_o, rsp_ready_i, rsp_nack_o, rsp_al_o, busy_o;
    logic [7:0] rsp_rdat_o;
    logic       start_o, stop_o, read_o, write_o, ack_o;
    logic [7:0] dat_o;
    logic       cmd_ack_i, ack_i, al_i;
    logic [7:0] dat_i;

    always #5 clk_i = ~clk_i;

    i2c_xfer_seq #(.RETRY_NUM(3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
        .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_wdat_i(req_wdat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdat_o(rsp_rdat_o),
        .rsp_nack_o(rsp_nack_o), .rsp_al_o(rsp_al_o), .busy_o(busy_o),
        .start_o(start_o), .stop_o(stop_o), .read_o(read_o), .write_o(write_o),
        .ack_o(ack_o), .dat_o(dat_o), .cmd_ack_i(cmd_ack_i), .ack_i(ack_i),
        .dat_i(dat_i), .al_i(al_i)
    );

    // Command word layout: {start, stop, read, write, ack, dat[7:0]}
    localparam logic [4:0] C_SW = 5'b10010;
    localparam logic [4:0] C_W  = 5'b00010;
    localparam logic [4:0] C_WS = 5'b01010;
    localparam logic [4:0] C_RS = 5'b01101;
    localparam logic [4:0] C_S  = 5'b01000;

    typedef struct {
        bit          rnw;
        logic [6:0]  dev;
        logic [7:0]  rg;
        logic [7:0]  wd;
        logic [7:0]  rb;
        logic [15:0] nack_mask;
        int          al_idx;
        int          rst_idx;
        bit          en_drop;
        int          exp_n;
        logic [12:0] exp_cmd [4];
        logic [7:0]  exp_rdat;
        bit          exp_nack;
        bit          exp_al;
    } xfer_t;

    xfer_t vecs[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic xfer_t mkv(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                                  input logic [7:0] wd, input logic [7:0] rb,
                                  input logic [15:0] nm, input int al_idx, input int rst_idx,
                                  input bit en_drop, input int exp_n,
                                  input logic [12:0] e0, input logic [12:0] e1,
                                  input logic [12:0] e2, input logic [12:0] e3,
                                  input logic [7:0] erd, input bit enk, input bit eal);
        xfer_t v;
        v.rnw = rnw; v.dev = dev; v.rg = rg; v.wd = wd; v.rb = rb;
        v.nack_mask = nm; v.al_idx = al_idx; v.rst_idx = rst_idx; v.en_drop = en_drop;
        v.exp_n = exp_n;
        v.exp_cmd[0] = e0; v.exp_cmd[1] = e1; v.exp_cmd[2] = e2; v.exp_cmd[3] = e3;
        v.exp_rdat = erd; v.exp_nack = enk; v.exp_al = eal;
        return v;
    endfunction

    function automatic logic [24:0] all_outs();
        return {start_o, stop_o, read_o, write_o, ack_o, dat_o, rsp_valid_o,
                rsp_rdat_o, rsp_nack_o, rsp_al_o, busy_o};
    endfunction

    task automatic run_xfer(input xfer_t v, input int k);
        logic [12:0] got [16];
        logic [12:0] w;
        int n = 0, hold = 0, zrun = 0, cyc = 0, last = 0;
        bit done = 1'b0;
        req_rnw_i = v.rnw; req_dev_i = v.dev; req_reg_i = v.rg; req_wdat_i = v.wd;
        req_valid_i = 1'b1;
        #1;
        check($sformatf("v%0d_req_ready", k), req_ready_o, 1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check($sformatf("v%0d_busy_start", k), busy_o, 1);
        if (v.en_drop) en_i = 1'b0;
        while (!done && cyc < 200) begin
            cmd_ack_i = 1'b0; al_i = 1'b0; ack_i = 1'b0;
            w = {start_o, stop_o, read_o, write_o, ack_o, dat_o};
            if (rsp_valid_o) begin
                done = 1'b1;
                check($sformatf("v%0d_rsp_latency", k), cyc - last, 1);
                check($sformatf("v%0d_cmds_idle_at_rsp", k), w, 0);
            end else begin
                if (w[12:8] != 5'b0) begin
                    if (hold == 0) begin
                        if (n > 0) check($sformatf("v%0d_gap%0d", k, n), zrun, 1);
                        if (n < 16) got[n] = w;
                        n++;
                        if (n - 1 == v.rst_idx) begin
                            rst_n_i = 1'b0;
                            @(negedge clk_i);
                            check($sformatf("v%0d_outs_in_reset", k), all_outs(), 0);
                            rst_n_i = 1'b1;
                            @(negedge clk_i);
                            check($sformatf("v%0d_ready_after_reset", k), req_ready_o, 1);
                            check($sformatf("v%0d_busy_after_reset", k), busy_o, 0);
                            return;
                        end
                    end
                    hold++;
                    zrun = 0;
                    if (hold == 2) begin
                        cmd_ack_i = 1'b1;
                        ack_i = v.nack_mask[n-1];
                        dat_i = v.rb;
                        if (v.al_idx == n - 1) al_i = 1'b1;
                        last = cyc;
                        hold = 0;
                    end
                end else begin
                    zrun++;
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        cmd_ack_i = 1'b0; al_i = 1'b0; ack_i = 1'b0;
        if (!done) begin
            check($sformatf("v%0d_timeout", k), 0, 1);
            return;
        end
        check($sformatf("v%0d_ncmd", k), n, v.exp_n);
        for (int i = 0; i < 4; i++)
            if (i < v.exp_n && i < n)
                check($sformatf("v%0d_cmd%0d", k, i), got[i], v.exp_cmd[i]);
        check($sformatf("v%0d_rdat", k), rsp_rdat_o, v.exp_rdat);
        check($sformatf("v%0d_nack", k), rsp_nack_o, v.exp_nack);
        check($sformatf("v%0d_al", k), rsp_al_o, v.exp_al);
        check($sformatf("v%0d_busy_resp", k), busy_o, 1);
        repeat (2) @(negedge clk_i);
        check($sformatf("v%0d_rsp_held", k), {rsp_valid_o, rsp_rdat_o, rsp_nack_o, rsp_al_o},
              {1'b1, v.exp_rdat, v.exp_nack, v.exp_al});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check($sformatf("v%0d_rsp_done", k), {rsp_valid_o, busy_o}, 0);
        if (v.en_drop) begin
            check($sformatf("v%0d_ready_disabled", k), req_ready_o, 0);
            en_i = 1'b1;
            #1;
            check($sformatf("v%0d_ready_reenabled", k), req_ready_o, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0; en_i = 1'b0; req_valid_i = 1'b0; req_rnw_i = 1'b0;
        req_dev_i = '0; req_reg_i = '0; req_wdat_i = '0; rsp_ready_i = 1'b0;
        cmd_ack_i = 1'b0; ack_i = 1'b0; dat_i = '0; al_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_outs", all_outs(), 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_en_low", req_ready_o, 0);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        check("no_accept_disabled", busy_o, 0);
        req_valid_i = 1'b0;
        en_i = 1'b1;
        #1;
        check("ready_en_high", req_ready_o, 1);

        vecs.push_back(mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 16'h0000, -1, -1, 0, 3,
                           {C_SW, 8'hA0}, {C_W, 8'h10}, {C_WS, 8'hA5}, 13'h0, 8'h00, 0, 0));
        vecs.push_back(mkv(1, 7'h50, 8'h22, 8'h00, 8'h3C, 16'h0000, -1, -1, 0, 4,
                           {C_SW, 8'hA0}, {C_W, 8'h22}, {C_SW, 8'hA1}, {C_RS, 8'h00}, 8'h3C, 0, 0));
        vecs.push_back(mkv(0, 7'h1A, 8'h33, 8'h77, 8'h00, 16'h0002, -1, -1, 1, 3,
                           {C_SW, 8'h34}, {C_W, 8'h33}, {C_S, 8'h00}, 13'h0, 8'h00, 1, 0));
        vecs.push_back(mkv(1, 7'h2C, 8'h80, 8'h00, 8'h99, 16'h0004, -1, -1, 0, 4,
                           {C_SW, 8'h58}, {C_W, 8'h80}, {C_SW, 8'h59}, {C_S, 8'h00}, 8'h00, 1, 0));
        vecs.push_back(mkv(0, 7'h01, 8'hFF, 8'h00, 8'h00, 16'h0004, -1, -1, 0, 3,
                           {C_SW, 8'h02}, {C_W, 8'hFF}, {C_WS, 8'h00}, 13'h0, 8'h00, 1, 0));
        vecs.push_back(mkv(1, 7'h00, 8'h00, 8'h00, 8'hFF, 16'h0008, -1, -1, 0, 4,
                           {C_SW, 8'h00}, {C_W, 8'h00}, {C_SW, 8'h01}, {C_RS, 8'h00}, 8'hFF, 0, 0));
        vecs.push_back(mkv(1, 7'h50, 8'h22, 8'h00, 8'h55, 16'h0000, 2, -1, 0, 3,
                           {C_SW, 8'hA0}, {C_W, 8'h22}, {C_SW, 8'hA1}, 13'h0, 8'h00, 0, 1));
`ifdef I2C_XFER_SEQ_RETRY_EN
        vecs.push_back(mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 16'h0005, -1, -1, 0, 7,
                           {C_SW, 8'hA0}, {C_S, 8'h00}, {C_SW, 8'hA0}, {C_S, 8'h00}, 8'h00, 0, 0));
        vecs.push_back(mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 16'h0055, -1, -1, 0, 8,
                           {C_SW, 8'hA0}, {C_S, 8'h00}, {C_SW, 8'hA0}, {C_S, 8'h00}, 8'h00, 1, 0));
`endif
        vecs.push_back(mkv(1, 7'h50, 8'h22, 8'h00, 8'h3C, 16'h0000, -1, 3, 0, 4,
                           {C_SW, 8'hA0}, {C_W, 8'h22}, {C_SW, 8'hA1}, {C_RS, 8'h00}, 8'h00, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk_i);
            run_xfer(vecs[k], k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
